// File: rtl/seq_alu_if.sv
// Request/response bundle between the pipeline controller and seq_alu.
// The controller is the master; the ALU is the slave.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             zero;
  logic             err;

  modport master (
    output start, alu_ctrl, data1, data2,
    input  busy, valid, data, zero, err
  );

  modport slave (
    input  start, alu_ctrl, data1, data2,
    output busy, valid, data, zero, err
  );
endinterface

// File: rtl/seq_alu.sv
// Execution-stage ALU: AND/OR/ADD/SUB in one cycle, MUL as a WIDTH-cycle
// shift-add behind a busy/valid handshake. All outputs are registered.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  seq_alu_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0] mplier, mplier_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] acc_sum;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] data, data_n;
  logic             zero, zero_n;
  logic             err, err_n;
  logic             valid, valid_n;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      data   <= '0;
      zero   <= 1'b1;
      err    <= 1'b0;
      valid  <= 1'b0;
    end else begin
      state  <= state_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      data   <= data_n;
      zero   <= zero_n;
      err    <= err_n;
      valid  <= valid_n;
    end
  end

  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    cnt_n    = cnt;
    data_n   = data;
    zero_n   = zero;
    err_n    = err;
    valid_n  = 1'b0;
    acc_sum  = mplier[0] ? (acc + mcand) : acc;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          unique case (bus.alu_ctrl)
            OP_AND, OP_OR, OP_ADD, OP_SUB: begin
              unique case (bus.alu_ctrl)
                OP_AND:  data_n = bus.data1 & bus.data2;
                OP_OR:   data_n = bus.data1 | bus.data2;
                OP_ADD:  data_n = bus.data1 + bus.data2;
                default: data_n = bus.data1 - bus.data2;
              endcase
              zero_n  = (data_n == '0);
              err_n   = 1'b0;
              valid_n = 1'b1;
            end
            OP_MUL: begin
              mcand_n  = bus.data1;
              mplier_n = bus.data2;
              acc_n    = '0;
              cnt_n    = '0;
              state_n  = MUL;
            end
            default: begin
              data_n  = '0;
              zero_n  = 1'b1;
              err_n   = 1'b1;
              valid_n = 1'b1;
            end
          endcase
        end
      end
      MUL: begin
        // Fixed-latency iteration: no early exit even if the multiplier empties.
        acc_n    = acc_sum;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          data_n  = acc_sum;
          zero_n  = (acc_sum == '0);
          err_n   = 1'b0;
          valid_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy  = (state == MUL);
  assign bus.valid = valid;
  assign bus.data  = data;
  assign bus.zero  = zero;
  assign bus.err   = err;
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu with hand-computed expectations.
module tb_seq_alu;
  localparam int WIDTH = 32;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_BAD = 3'b110;

  logic clk;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; returns at the following negedge, after the DUT has sampled them.
  task automatic applyStimulus(input logic st, input logic [2:0] code,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.start    = st;
    bus.alu_ctrl = code;
    bus.data1    = a;
    bus.data2    = b;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic v, input logic [WIDTH-1:0] d,
                             input logic z, input logic e, input logic bz);
    cmp({tag, ".valid"}, WIDTH'(bus.valid), WIDTH'(v));
    cmp({tag, ".data"},  bus.data,          d);
    cmp({tag, ".zero"},  WIDTH'(bus.zero),  WIDTH'(z));
    cmp({tag, ".err"},   WIDTH'(bus.err),   WIDTH'(e));
    cmp({tag, ".busy"},  WIDTH'(bus.busy),  WIDTH'(bz));
  endtask

  // Starts a MUL, counts busy cycles (bounded), optionally pulses an ADD 1+1 mid-flight.
  task automatic runMul(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp, input int injectAt);
    int   busyCycles;
    logic overlap;
    busyCycles = 0;
    overlap    = 1'b0;
    applyStimulus(1'b1, OP_MUL, a, b);
    for (int i = 0; i < 40 && bus.busy === 1'b1; i++) begin
      busyCycles++;
      if (bus.valid !== 1'b0) overlap = 1'b1;
      if (i == injectAt) applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1);
      else               applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0);
    end
    cmp({tag, ".busy_cycles"}, WIDTH'(busyCycles), WIDTH'(32));
    cmp({tag, ".valid_during_busy"}, WIDTH'(overlap), '0);
    checkOutput(tag, 1'b1, exp, (exp == '0), 1'b0, 1'b0);
    applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0);
    checkOutput({tag, "_after"}, 1'b0, exp, (exp == '0), 1'b0, 1'b0);
  endtask

  initial begin
    logic sawValid;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.alu_ctrl = OP_AND;
    bus.data1    = '0;
    bus.data2    = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    applyStimulus(1'b1, OP_AND, 32'h0F0F00FF, 32'h00FF0F0F);
    checkOutput("and", 1'b1, 32'h000F000F, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_OR, 32'h0F0F00FF, 32'h00FF0F0F);
    checkOutput("or_b2b", 1'b1, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_ADD, 32'h1, 32'h1);
    checkOutput("idle_hold", 1'b0, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, OP_ADD, 32'hFFFFFFFF, 32'h00000001);
    checkOutput("add_wrap", 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_SUB, 32'h12345678, 32'h12345678);
    checkOutput("sub_zero", 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_SUB, 32'd5, 32'd7);
    checkOutput("sub_neg", 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);

    runMul("mul_7x6", 32'd7, 32'd6, 32'd42, -1);
    runMul("mul_neg", 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, -1);
    runMul("mul_ovf", 32'h80000000, 32'd2, 32'h0, -1);
    runMul("mul_ignore", 32'd3, 32'd4, 32'd12, 3);

    applyStimulus(1'b1, OP_MUL, 32'd9, 32'd9);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0);
    rst = 1'b1;
    applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0);
    rst = 1'b0;
    checkOutput("mul_reset", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0);
      if (bus.valid !== 1'b0) sawValid = 1'b1;
    end
    cmp("mul_reset.no_valid", WIDTH'(sawValid), '0);
    applyStimulus(1'b1, OP_ADD, 32'd2, 32'd3);
    checkOutput("add_after_reset", 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, OP_BAD, 32'h0000FFFF, 32'h0000FFFF);
    checkOutput("illegal", 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0);
    checkOutput("illegal_hold", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_OR, 32'd1, 32'd2);
    checkOutput("err_clear", 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
